// File: rtl/vpifo_pkg.sv
// Shared definitions for the virtual-PIFO pop drainer: FSM states and the
// default widths used when instantiating the drainer.
package vpifo_pkg;

  localparam int PTW_DEF      = 16;
  localparam int TREE_NUM_DEF = 4;
  localparam int CNTW_DEF     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/vpifo_obuf_fifo.sv
// Synchronous output buffer holding popped data together with its tree id.
// Head entry is presented combinationally and reads as zero when empty.
module vpifo_obuf_fifo #(
  parameter int DW    = 16,
  parameter int TW    = 2,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [TW-1:0] wr_tree,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [TW-1:0] rd_tree,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW+TW-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [DW+TW-1:0] head;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= {wr_tree, wr_data};
  end

  assign head    = mem[rptr];
  assign rd_data = empty ? '0 : head[DW-1:0];
  assign rd_tree = empty ? '0 : head[DW+TW-1:DW];

endmodule

// File: rtl/vpifo_pop_drainer.sv
// Drains a fixed number of elements from one virtual PIFO tree and streams
// them out over valid/ready, never issuing more pops than the buffer can hold.
module vpifo_pop_drainer
  import vpifo_pkg::*;
#(
  parameter int PTW         = PTW_DEF,
  parameter int TREE_NUM    = TREE_NUM_DEF,
  parameter int CNTW        = CNTW_DEF,
  parameter int POP_LAT     = 2,
  parameter int OBUF_DEPTH  = 4,
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_start,
  input  logic [TREE_NUM_BITS-1:0] i_tree_id,
  input  logic [CNTW-1:0]          i_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pop,
  output logic [TREE_NUM_BITS-1:0] o_pop_tree_id,
  input  logic [PTW-1:0]           i_pop_data,
  input  logic                     i_task_fifo_full,
  output logic                     o_valid,
  output logic [PTW-1:0]           o_data,
  output logic [TREE_NUM_BITS-1:0] o_tree_id,
  input  logic                     i_ready,
  output logic [1:0]               o_dbg_state
);

  localparam int IFW = $clog2(POP_LAT + 1) + 1;
  localparam int OCW = $clog2(OBUF_DEPTH) + 1;
  localparam int SW  = ((IFW > OCW) ? IFW : OCW) + 1;

  // Handshake: an output entry transfers in any cycle where o_valid and
  // i_ready are both high at the clock edge; o_valid never depends on i_ready.

  drain_state_e             state;
  drain_state_e             state_n;
  logic [TREE_NUM_BITS-1:0] tree_q;
  logic [CNTW-1:0]          remaining;
  logic [IFW-1:0]           inflight;
  logic [POP_LAT-1:0]       pipe_v;
  logic                     capture;
  logic                     obuf_full;
  logic                     obuf_empty;
  logic [OCW-1:0]           occ;
  logic [SW-1:0]            outstanding;

  assign capture     = pipe_v[POP_LAT-1];
  assign outstanding = SW'(inflight) + SW'(occ);
  assign o_busy      = (state != ST_IDLE);
  assign o_pop_tree_id = o_busy ? tree_q : '0;
  assign o_valid     = !obuf_empty;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= ST_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    o_pop   = 1'b0;
    o_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_n = (i_count == '0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        // In-flight pops already own a buffer slot, so they count against space.
        o_pop = (remaining != '0) && !i_task_fifo_full && !obuf_full &&
                (outstanding < SW'(OBUF_DEPTH));
        if (remaining == '0 || (o_pop && remaining == CNTW'(1))) state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (inflight == '0 && obuf_empty) state_n = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tree_q    <= '0;
      remaining <= '0;
      inflight  <= '0;
      pipe_v    <= '0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        tree_q    <= i_tree_id;
        remaining <= i_count;
      end else if (o_pop) begin
        remaining <= remaining - CNTW'(1);
      end
      pipe_v[0] <= o_pop;
      for (int i = 1; i < POP_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      case ({o_pop, capture})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  vpifo_obuf_fifo #(
    .DW    (PTW),
    .TW    (TREE_NUM_BITS),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk     (i_clk),
    .rst_n   (i_arst_n),
    .wr_en   (capture),
    .wr_data (i_pop_data),
    .wr_tree (tree_q),
    .rd_en   (o_valid && i_ready),
    .rd_data (o_data),
    .rd_tree (o_tree_id),
    .full    (obuf_full),
    .empty   (obuf_empty),
    .count   (occ)
  );

endmodule

// File: doc/vpifo_pop_drainer.md
VPIFO_POP_DRAINER -- requirements
Module: vpifo_pop_drainer

Interface
REQ-001 SHALL have parameter PTW, default 16, meaning pop-data width.
REQ-002 SHALL have parameter TREE_NUM, default 4, meaning number of virtual trees; TREE_NUM_BITS = $clog2(TREE_NUM).
REQ-003 SHALL have parameter CNTW, default 12, meaning drain-count width.
REQ-004 SHALL have parameter POP_LAT, default 2, meaning fixed cycles from o_pop to valid i_pop_data.
REQ-005 SHALL have parameter OBUF_DEPTH, default 4, meaning output buffer entries (power of two).
REQ-006 SHALL have ports: i_clk in 1 clock; i_arst_n in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: i_start in 1 drain command; i_tree_id in TREE_NUM_BITS target tree; i_count in CNTW elements to pop.
REQ-008 SHALL have ports: o_busy out 1 command active; o_done out 1 one-cycle completion pulse.
REQ-009 SHALL have ports: o_pop out 1 pop request to PIFO level; o_pop_tree_id out TREE_NUM_BITS; i_pop_data in PTW; i_task_fifo_full in 1 PIFO stall.
REQ-010 SHALL have ports: o_valid out 1; o_data out PTW; o_tree_id out TREE_NUM_BITS; i_ready in 1 (valid/ready stream).

Function
REQ-011 SHALL implement FSM IDLE -> DRAIN -> FLUSH -> DONE -> IDLE.
REQ-012 IDLE: i_start=1 latches i_tree_id and i_count, goes to DRAIN; if i_count=0, goes directly to DONE.
REQ-013 i_start SHALL be ignored when not in IDLE.
REQ-014 DRAIN: o_pop=1 in a cycle only if remaining>0, i_task_fifo_full=0, and (in-flight + buffer occupancy) < OBUF_DEPTH.
REQ-015 Each issued pop SHALL decrement remaining by 1; at remaining=0 go to FLUSH.
REQ-016 o_pop_tree_id SHALL equal the latched tree id while busy, 0 in IDLE.
REQ-017 i_pop_data SHALL be captured exactly POP_LAT cycles after each o_pop=1, via a POP_LAT-deep valid shift pipe.
REQ-018 Captured data SHALL be written to the output buffer with the latched tree id, in pop order; overflow SHALL be impossible by REQ-014.
REQ-019 Output: o_valid=1 when buffer non-empty; entry removed on o_valid&i_ready; simultaneous write and read in the same cycle SHALL keep occupancy unchanged.
REQ-020 FLUSH: stay until in-flight=0 and buffer empty, then DONE.
REQ-021 DONE: o_done=1 for exactly one cycle, then IDLE; o_busy=1 in DRAIN, FLUSH, DONE.
REQ-022 In-flight counter SHALL be width $clog2(POP_LAT+1)+1; occupancy counter width $clog2(OBUF_DEPTH)+1; read/write pointers wrap modulo OBUF_DEPTH.
REQ-023 o_data and o_tree_id SHALL be the buffer head; don't-care when o_valid=0.

Reset
REQ-024 On i_arst_n=0 asynchronously: state=IDLE, o_pop=0, o_busy=0, o_done=0, o_valid=0, o_pop_tree_id=0, o_data=0, o_tree_id=0, counters, pointers and pipe valids=0.
REQ-025 Reset mid-operation SHALL discard in-flight pops and buffered data; returns arriving after reset release SHALL be ignored.

Structure
REQ-026 A shared package vpifo_pkg SHALL hold the FSM state enum and default PTW/TREE_NUM/CNTW constants.
REQ-027 The output buffer SHALL be a sub-module vpifo_obuf_fifo (sync FIFO, data+tree id, full/empty/count outputs).

Verification
REQ-028 start tree=2 count=4, ready=1, full=0, stub returns 0x2000..0x2003 -> 4 pops on consecutive cycles, o_data 0x2000..0x2003 in order, o_done once.
REQ-029 count=10, i_ready=0 -> exactly 4 pops issued then o_pop held 0; raise ready -> remaining 6 popped, all 10 delivered in order.
REQ-030 count=0 -> no o_pop, o_done pulses within 2 cycles of start.
REQ-031 count=3, i_task_fifo_full=1 for 5 cycles -> no o_pop during those cycles; 3 pops after deassertion.
REQ-032 i_start tree=1 while busy (tree=3) -> ignored; o_pop_tree_id stays 3.
REQ-033 reset asserted with 2 pops in flight -> all outputs 0 immediately; after release o_valid stays 0, state IDLE.
